// File: rtl/hamming_pkg.sv
// Shared constants, syndrome masks and controller state encoding for the
// Hamming(7,4) stream decoder.
package hamming_pkg;

   localparam int CW_W   = 7;
   localparam int DATA_W = 4;
   localparam int SYN_W  = 3;

   // Each mask selects the codeword bits covered by one syndrome bit.
   localparam logic [CW_W-1:0] SYN0_MASK = 7'b101_0101;
   localparam logic [CW_W-1:0] SYN1_MASK = 7'b110_0110;
   localparam logic [CW_W-1:0] SYN2_MASK = 7'b111_1000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) syndrome, single-bit correction and data extraction.
module hamming74_correct
   import hamming_pkg::*;
(
   input  logic [CW_W-1:0]   cw_i,
   output logic [DATA_W-1:0] data_o,
   output logic [SYN_W-1:0]  syn_o,
   output logic              err_o
);

   logic [CW_W-1:0] flip;
   logic [CW_W-1:0] fixed_cw;

   always_comb begin
      syn_o[0] = ^(cw_i & SYN0_MASK);
      syn_o[1] = ^(cw_i & SYN1_MASK);
      syn_o[2] = ^(cw_i & SYN2_MASK);
      err_o    = (syn_o != 3'd0);
      // A nonzero syndrome is the 1-based position of the bad bit.
      flip     = err_o ? (CW_W'(1) << (syn_o - 3'd1)) : '0;
      fixed_cw = cw_i ^ flip;
      data_o   = {fixed_cw[2], fixed_cw[4], fixed_cw[5], fixed_cw[6]};
   end

endmodule

// File: rtl/hamming_stream_ctrl.sv
// Enable/drain controlled two-stage Hamming(7,4) decode pipeline with saturating
// statistics. Define HAM_ERR_LOG_EN to add the last-syndrome log outputs.
module hamming_stream_ctrl
   import hamming_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   cw_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              err_flag,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  cw_cnt,
`ifdef HAM_ERR_LOG_EN
   output logic [SYN_W-1:0]  last_syn,
   output logic              last_pos_valid,
`endif
   output logic [CNT_W-1:0]  err_cnt
);

   state_t              state_q, state_d;
   logic                done_q, done_d;
   logic                s1_valid_q, s1_valid_d;
   logic [CW_W-1:0]     s1_cw_q, s1_cw_d;
   logic                s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0]   s2_data_q, s2_data_d;
   logic                s2_err_q, s2_err_d;
   logic [CNT_W-1:0]    cw_cnt_q, cw_cnt_d;
   logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
   logic                s2_adv, s1_adv, in_fire, out_fire;
   logic [DATA_W-1:0]   cor_data;
   logic                cor_err;
`ifdef HAM_ERR_LOG_EN
   logic [SYN_W-1:0]    cor_syn;
   logic [SYN_W-1:0]    s2_syn_q, s2_syn_d;
   logic [SYN_W-1:0]    last_syn_q, last_syn_d;
   logic                last_pos_valid_q, last_pos_valid_d;
`else
   logic [SYN_W-1:0]    syn_unused;
`endif

   hamming74_correct u_correct (
      .cw_i   (s1_cw_q),
      .data_o (cor_data),
`ifdef HAM_ERR_LOG_EN
      .syn_o  (cor_syn),
`else
      .syn_o  (syn_unused),
`endif
      .err_o  (cor_err)
   );

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE:  if (en) state_d = RUN;
         RUN:   if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en) begin
               state_d = RUN;
            end else if (!s1_valid_q && !s2_valid_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Valid/ready: a beat moves when the sender's valid and the receiver's
   // ready are both high at a clock edge; in_ready never looks at in_valid.
   always_comb begin
      s2_adv   = !s2_valid_q || out_ready;
      s1_adv   = s1_valid_q && s2_adv;
      in_ready = (state_q == RUN) && (!s1_valid_q || s2_adv);
      in_fire  = in_valid && in_ready;
      out_fire = s2_valid_q && out_ready;

      s1_valid_d = s1_valid_q;
      s1_cw_d    = s1_cw_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_cw_d    = cw_in;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_err_d   = s2_err_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = cor_data;
            s2_err_d  = cor_err;
         end
      end
   end

`ifdef HAM_ERR_LOG_EN
   always_comb begin
      s2_syn_d         = (s1_adv) ? cor_syn : s2_syn_q;
      last_syn_d       = last_syn_q;
      last_pos_valid_d = last_pos_valid_q;
      if (clr) begin
         last_syn_d       = '0;
         last_pos_valid_d = 1'b0;
      end else if (out_fire && s2_err_q) begin
         last_syn_d       = s2_syn_q;
         last_pos_valid_d = 1'b1;
      end
   end
`endif

   // Counters stick at all-ones; clr wins over a same-cycle delivery.
   always_comb begin
      cw_cnt_d  = cw_cnt_q;
      err_cnt_d = err_cnt_q;
      if (clr) begin
         cw_cnt_d  = '0;
         err_cnt_d = '0;
      end else if (out_fire) begin
         if (cw_cnt_q != '1) cw_cnt_d = cw_cnt_q + CNT_W'(1);
         if (s2_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_cw_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_err_q   <= 1'b0;
         cw_cnt_q   <= '0;
         err_cnt_q  <= '0;
`ifdef HAM_ERR_LOG_EN
         s2_syn_q         <= '0;
         last_syn_q       <= '0;
         last_pos_valid_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         s1_valid_q <= s1_valid_d;
         s1_cw_q    <= s1_cw_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_err_q   <= s2_err_d;
         cw_cnt_q   <= cw_cnt_d;
         err_cnt_q  <= err_cnt_d;
`ifdef HAM_ERR_LOG_EN
         s2_syn_q         <= s2_syn_d;
         last_syn_q       <= last_syn_d;
         last_pos_valid_q <= last_pos_valid_d;
`endif
      end
   end

   assign out_valid = s2_valid_q;
   assign data_out  = s2_data_q;
   assign err_flag  = s2_err_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign cw_cnt    = cw_cnt_q;
   assign err_cnt   = err_cnt_q;
`ifdef HAM_ERR_LOG_EN
   assign last_syn       = last_syn_q;
   assign last_pos_valid = last_pos_valid_q;
`endif

endmodule

// File: tb/tb_hamming_stream_ctrl.sv
// Directed bench for hamming_stream_ctrl: decode, correction, backpressure,
// drain, reset and counter saturation.
module tb_hamming_stream_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst, en, clr, in_valid, out_ready;
   logic [6:0]       cw_in;
   logic             in_ready, out_valid, err_flag, busy, done;
   logic [3:0]       data_out;
   logic [CNT_W-1:0] cw_cnt, err_cnt;
`ifdef HAM_ERR_LOG_EN
   logic [2:0]       last_syn;
   logic             last_pos_valid;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [4:0] got_q[$];
   int         got_cyc[$];
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   hamming_stream_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cw_in     (cw_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .err_flag  (err_flag),
      .busy      (busy),
      .done      (done),
      .cw_cnt    (cw_cnt),
`ifdef HAM_ERR_LOG_EN
      .last_syn       (last_syn),
      .last_pos_valid (last_pos_valid),
`endif
      .err_cnt   (err_cnt)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && out_valid && out_ready) begin
         got_q.push_back({err_flag, data_out});
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      logic [6:0] vec[5];
      logic [4:0] prev_data;
      logic       prev_stall;
      logic       saw_low;
      int         i, n, n_done, base;

      rst = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0; cw_in = '0; out_ready = 1'b0;
      nxt(); nxt();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data", data_out, 0);
      chk("rst_err", err_flag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cw_cnt", cw_cnt, 0);
      chk("rst_err_cnt", err_cnt, 0);
`ifdef HAM_ERR_LOG_EN
      chk("rst_last_syn", last_syn, 0);
      chk("rst_last_pv", last_pos_valid, 0);
`endif
      rst = 1'b0;

      // Test 1: clean codeword, two-cycle latency
      en = 1'b1; out_ready = 1'b1;
      nxt();
      chk("t1_busy", busy, 1);
      chk("t1_in_ready", in_ready, 1);
      in_valid = 1'b1; cw_in = 7'h66;
      nxt();
      in_valid = 1'b0;
      chk("t1_not_yet", out_valid, 0);
      nxt();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_data", data_out, 4'b1011);
      chk("t1_err", err_flag, 0);
      nxt();
      chk("t1_cw_cnt", cw_cnt, 1);
      chk("t1_err_cnt", err_cnt, 0);
      chk("t1_drained", out_valid, 0);

      // Test 2: position 5 flipped
      in_valid = 1'b1; cw_in = 7'h76;
      nxt();
      in_valid = 1'b0;
      nxt();
      chk("t2_out_valid", out_valid, 1);
      chk("t2_data", data_out, 4'b1011);
      chk("t2_err", err_flag, 1);
      nxt();
      chk("t2_cw_cnt", cw_cnt, 2);
      chk("t2_err_cnt", err_cnt, 1);
`ifdef HAM_ERR_LOG_EN
      chk("t2_last_syn", last_syn, 5);
      chk("t2_last_pv", last_pos_valid, 1);
`endif

      // Test 3: all seven single-bit flips back-to-back
      clr = 1'b1;
      nxt();
      clr = 1'b0;
      chk("t3_clr_cw", cw_cnt, 0);
      chk("t3_clr_err", err_cnt, 0);
      got_q.delete(); got_cyc.delete(); exp_q.delete();
      for (int k = 0; k < 7; k++) begin
         chk("t3_in_ready", in_ready, 1);
         in_valid = 1'b1; cw_in = 7'h66 ^ (7'h01 << k);
         exp_q.push_back(5'h1B);
         nxt();
      end
      in_valid = 1'b0;
      for (int t = 0; t < 20 && got_q.size() < 7; t++) nxt();
      nxt();
      chk("t3_count", got_q.size(), 7);
      for (int k = 0; k < 7 && k < got_q.size(); k++) chk("t3_beat", got_q[k], exp_q[k]);
      if (got_cyc.size() == 7) chk("t3_one_per_cycle", got_cyc[6] - got_cyc[0], 6);
      chk("t3_err_cnt", err_cnt, 7);
      chk("t3_cw_cnt", cw_cnt, 7);

      // Test 4: five beats with a four-cycle output stall
      clr = 1'b1;
      nxt();
      clr = 1'b0;
      got_q.delete(); exp_q.delete();
      vec[0] = 7'h07; vec[1] = 7'h19; vec[2] = 7'h2A; vec[3] = 7'h4B; vec[4] = 7'h7E;
      exp_q.push_back(5'h08); exp_q.push_back(5'h04); exp_q.push_back(5'h02);
      exp_q.push_back(5'h01); exp_q.push_back(5'h1F);
      i = 0; prev_stall = 1'b0; prev_data = '0; saw_low = 1'b0;
      for (int c = 0; c < 60 && got_q.size() < 5; c++) begin
         nxt();
         if (prev_stall) begin
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_data", {err_flag, data_out}, prev_data);
         end
         out_ready = !(c >= 2 && c < 6);
         in_valid  = (i < 5);
         cw_in     = (i < 5) ? vec[i] : 7'h00;
         #1;
         if (in_valid && !in_ready) saw_low = 1'b1;
         prev_stall = out_valid && !out_ready;
         prev_data  = {err_flag, data_out};
         if (in_valid && in_ready) i++;
      end
      nxt();
      in_valid = 1'b0; out_ready = 1'b1;
      chk("t4_in_ready_fell", saw_low, 1);
      chk("t4_count", got_q.size(), 5);
      for (int k = 0; k < 5 && k < got_q.size(); k++) chk("t4_beat", got_q[k], exp_q[k]);
      chk("t4_cw_cnt", cw_cnt, 5);
      chk("t4_err_cnt", err_cnt, 1);

      // Test 5: drop en with two beats in flight, then reset mid-stream
      got_q.delete();
      in_valid = 1'b1; cw_in = 7'h66;
      nxt();
      cw_in = 7'h76;
      nxt();
      in_valid = 1'b0; en = 1'b0;
      nxt();
      chk("t5_in_ready", in_ready, 0);
      chk("t5_busy_drain", busy, 1);
      n_done = 0;
      for (int t = 0; t < 10; t++) begin
         if (done) n_done++;
         nxt();
      end
      chk("t5_done_once", n_done, 1);
      chk("t5_busy_idle", busy, 0);
      chk("t5_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("t5_beat0", got_q[0], 5'h0B);
         chk("t5_beat1", got_q[1], 5'h1B);
      end

      en = 1'b1; out_ready = 1'b0;
      nxt();
      in_valid = 1'b1; cw_in = 7'h66;
      nxt();
      cw_in = 7'h76;
      nxt();
      in_valid = 1'b0;
      chk("t5_pipe_full", out_valid, 1);
      base = got_q.size();
      rst = 1'b1; en = 1'b0;
      nxt();
      chk("t5r_out_valid", out_valid, 0);
      chk("t5r_in_ready", in_ready, 0);
      chk("t5r_busy", busy, 0);
      chk("t5r_data", data_out, 0);
      chk("t5r_err", err_flag, 0);
      chk("t5r_cw_cnt", cw_cnt, 0);
      chk("t5r_err_cnt", err_cnt, 0);
      rst = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 4; t++) nxt();
      chk("t5r_no_output", got_q.size(), base);
      chk("t5r_still_empty", out_valid, 0);

      // Test 6: saturation at 15, then clr against a same-cycle handshake
      en = 1'b1;
      nxt();
      n = 0;
      for (int c = 0; c < 60; c++) begin
         in_valid = (n < 17);
         cw_in    = 7'h76;
         #1;
         if (in_valid && in_ready) n++;
         if (!in_valid) break;
         nxt();
      end
      chk("t6_sent", n, 17);
      for (int t = 0; t < 5; t++) nxt();
      chk("t6_cw_sat", cw_cnt, 15);
      chk("t6_err_sat", err_cnt, 15);
      in_valid = 1'b1; cw_in = 7'h76;
      nxt();
      in_valid = 1'b0;
      nxt();
      chk("t6_pre_clr_valid", out_valid, 1);
      clr = 1'b1;
      nxt();
      clr = 1'b0;
      chk("t6_clr_cw", cw_cnt, 0);
      chk("t6_clr_err", err_cnt, 0);
`ifdef HAM_ERR_LOG_EN
      chk("t6_clr_last_pv", last_pos_valid, 0);
      chk("t6_clr_last_syn", last_syn, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
